// File: rtl/reversi_flip_engine_if.sv
// Handshake and board bus between the move controller and the flip engine.
interface reversi_flip_engine_if;
    logic         start;
    logic [2:0]   x;
    logic [2:0]   y;
    logic [7:0]   dir_mask;
    logic [127:0] board_in;
    logic         player_black;
    logic         busy;
    logic         done;
    logic         illegal;
    logic [5:0]   flip_count;
    logic [127:0] board_out;

    modport master (
        output start, x, y, dir_mask, board_in, player_black,
        input  busy, done, illegal, flip_count, board_out
    );

    modport slave (
        input  start, x, y, dir_mask, board_in, player_black,
        output busy, done, illegal, flip_count, board_out
    );
endinterface

// File: rtl/reversi_flip_engine.sv
// Reversi move applier: places the mover's disc and flips bracketed discs,
// scanning and writing one cell per clock along each requested direction.
module reversi_flip_engine (
    input logic                   clk,
    input logic                   resetn,
    reversi_flip_engine_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StPlace, StSelect, StScan, StFlip, StDone} state_e;

    state_e       state_q, state_d;
    logic [2:0]   x_q, x_d, y_q, y_d;
    logic [2:0]   cx_q, cx_d, cy_q, cy_d;
    logic [2:0]   dir_q, dir_d;
    logic [2:0]   run_q, run_d;
    logic [7:0]   mask_q, mask_d;
    logic         black_q, black_d;
    logic [127:0] board_q, board_d;
    logic [127:0] orig_q, orig_d;
    logic [5:0]   flip_q, flip_d;
    logic         illegal_q, illegal_d;
    logic         done_q, done_d;

    logic signed [3:0] dx, dy;
    logic [3:0]        nx, ny;
    logic [1:0]        own, opp, next_cell, target_cell;
    logic              off_board;
    logic [2:0]        sel;

    always_comb begin
        dx = 4'sd0;
        dy = 4'sd0;
        unique case (dir_q)
            3'd0: begin dx =  4'sd0; dy = -4'sd1; end
            3'd1: begin dx =  4'sd0; dy =  4'sd1; end
            3'd2: begin dx = -4'sd1; dy =  4'sd0; end
            3'd3: begin dx =  4'sd1; dy =  4'sd0; end
            3'd4: begin dx = -4'sd1; dy = -4'sd1; end
            3'd5: begin dx = -4'sd1; dy =  4'sd1; end
            3'd6: begin dx =  4'sd1; dy = -4'sd1; end
            3'd7: begin dx =  4'sd1; dy =  4'sd1; end
            default: ;
        endcase
    end

    // Coordinates span -1..8; bit 3 set means either end is off the board.
    assign nx          = {1'b0, cx_q} + dx;
    assign ny          = {1'b0, cy_q} + dy;
    assign off_board   = nx[3] | ny[3];
    assign own         = {1'b1, black_q};
    assign opp         = {1'b1, ~black_q};
    assign next_cell   = board_q[{ny[2:0], nx[2:0], 1'b0} +: 2];
    assign target_cell = board_q[{y_q, x_q, 1'b0} +: 2];

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        dir_d     = dir_q;
        run_d     = run_q;
        mask_d    = mask_q;
        black_d   = black_q;
        board_d   = board_q;
        orig_d    = orig_q;
        flip_d    = flip_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    x_d       = bus.x;
                    y_d       = bus.y;
                    mask_d    = bus.dir_mask;
                    black_d   = bus.player_black;
                    board_d   = bus.board_in;
                    orig_d    = bus.board_in;
                    flip_d    = 6'd0;
                    illegal_d = 1'b0;
                    state_d   = StPlace;
                end
            end
            StPlace: begin
                flip_d = 6'd0;
                if (target_cell[1]) begin
                    board_d = orig_q;
                    state_d = StDone;
                end else begin
                    board_d[{y_q, x_q, 1'b0} +: 2] = own;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (mask_q == 8'd0) begin
                    state_d = StDone;
                end else begin
                    dir_d   = sel;
                    mask_d  = mask_q & (mask_q - 8'd1);
                    cx_d    = x_q;
                    cy_d    = y_q;
                    run_d   = 3'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (off_board || !next_cell[1]) begin
                    state_d = StSelect;
                end else if (next_cell == opp) begin
                    run_d = run_q + 3'd1;
                    cx_d  = nx[2:0];
                    cy_d  = ny[2:0];
                end else if (run_q == 3'd0) begin
                    state_d = StSelect;
                end else begin
                    cx_d    = x_q;
                    cy_d    = y_q;
                    state_d = StFlip;
                end
            end
            StFlip: begin
                cx_d = nx[2:0];
                cy_d = ny[2:0];
                board_d[{ny[2:0], nx[2:0], 1'b0} +: 2] = own;
                flip_d = flip_q + 6'd1;
                run_d  = run_q - 3'd1;
                if (run_q == 3'd1) state_d = StSelect;
            end
            StDone: begin
                done_d = 1'b1;
                if (flip_q == 6'd0) begin
                    illegal_d = 1'b1;
                    board_d   = orig_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            cx_q      <= 3'd0;
            cy_q      <= 3'd0;
            dir_q     <= 3'd0;
            run_q     <= 3'd0;
            mask_q    <= 8'd0;
            black_q   <= 1'b0;
            board_q   <= 128'd0;
            orig_q    <= 128'd0;
            flip_q    <= 6'd0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            dir_q     <= dir_d;
            run_q     <= run_d;
            mask_q    <= mask_d;
            black_q   <= black_d;
            board_q   <= board_d;
            orig_q    <= orig_d;
            flip_q    <= flip_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy       = (state_q == StPlace) || (state_q == StSelect) ||
                            (state_q == StScan)  || (state_q == StFlip);
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
    assign bus.flip_count = flip_q;
    assign bus.board_out  = board_q;

endmodule

// File: tb/tb_reversi_flip_engine.sv
// Directed bench for reversi_flip_engine: each scenario task checks its own results.
module tb_reversi_flip_engine;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    reversi_flip_engine_if bus ();

    reversi_flip_engine dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] set_cell(input logic [127:0] b, input int cx, input int cy,
                                              input logic [1:0] v);
        b[2*(8*cy+cx) +: 2] = v;
        return b;
    endfunction

    function automatic logic [127:0] opening_board();
        logic [127:0] b;
        b = 128'd0;
        b = set_cell(b, 3, 3, 2'b10);
        b = set_cell(b, 4, 4, 2'b10);
        b = set_cell(b, 4, 3, 2'b11);
        b = set_cell(b, 3, 4, 2'b11);
        return b;
    endfunction

    // Starts a move and counts cycles until done; lat = -1 on timeout.
    // A nonzero poke_at pulses start with a different move while the engine is busy.
    task automatic run_move(input logic [2:0] mx, input logic [2:0] my, input logic [7:0] mask,
                            input logic [127:0] b, input logic black, input int poke_at,
                            output int lat);
        @(posedge clk);
        #1;
        bus.x            = mx;
        bus.y            = my;
        bus.dir_mask     = mask;
        bus.board_in     = b;
        bus.player_black = black;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (c == poke_at) begin
                bus.x        = 3'd3;
                bus.y        = 3'd3;
                bus.dir_mask = 8'hFF;
                bus.board_in = 128'd0;
                bus.start    = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b illegal=%b want 0 0 0",
                     bus.busy, bus.done, bus.illegal);
        end
        total++;
        if (bus.flip_count !== 6'd0 || bus.board_out !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: flip=%0d board=%h want 0 0", bus.flip_count, bus.board_out);
        end
        resetn = 1'b1;
    endtask

    task automatic test_opening();
        int lat;
        logic [127:0] exp;
        exp = set_cell(opening_board(), 3, 2, 2'b11);
        exp = set_cell(exp, 3, 3, 2'b11);
        run_move(3'd3, 3'd2, 8'h02, opening_board(), 1'b1, 0, lat);
        total++;
        if (lat !== 7) begin
            bad++;
            $display("FAIL opening_latency: got %0d want 7", lat);
        end
        total++;
        if (bus.illegal !== 1'b0 || bus.flip_count !== 6'd1) begin
            bad++;
            $display("FAIL opening_result: illegal=%b flip=%0d want 0 1", bus.illegal, bus.flip_count);
        end
        total++;
        if (bus.board_out !== exp) begin
            bad++;
            $display("FAIL opening_board: got %h want %h", bus.board_out, exp);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.board_out !== exp || bus.flip_count !== 6'd1) begin
            bad++;
            $display("FAIL opening_hold: done=%b flip=%0d want 0 1", bus.done, bus.flip_count);
        end
    endtask

    task automatic test_all_dirs();
        int lat;
        logic [127:0] exp;
        exp = set_cell(opening_board(), 3, 2, 2'b11);
        exp = set_cell(exp, 3, 3, 2'b11);
        run_move(3'd3, 3'd2, 8'hFF, opening_board(), 1'b1, 0, lat);
        total++;
        if (lat < 1 || lat >= 64) begin
            bad++;
            $display("FAIL alldirs_latency: got %0d want 1..63", lat);
        end
        total++;
        if (bus.illegal !== 1'b0 || bus.flip_count !== 6'd1 || bus.board_out !== exp) begin
            bad++;
            $display("FAIL alldirs_result: illegal=%b flip=%0d board=%h want 0 1 %h",
                     bus.illegal, bus.flip_count, bus.board_out, exp);
        end
    endtask

    task automatic test_multi_dir();
        int lat;
        logic [127:0] b, exp;
        b = 128'd0;
        b = set_cell(b, 1, 1, 2'b10);
        b = set_cell(b, 2, 2, 2'b10);
        b = set_cell(b, 0, 1, 2'b10);
        b = set_cell(b, 0, 2, 2'b10);
        b = set_cell(b, 3, 3, 2'b11);
        b = set_cell(b, 0, 3, 2'b11);
        exp = set_cell(b, 0, 0, 2'b11);
        exp = set_cell(exp, 1, 1, 2'b11);
        exp = set_cell(exp, 2, 2, 2'b11);
        exp = set_cell(exp, 0, 1, 2'b11);
        exp = set_cell(exp, 0, 2, 2'b11);
        run_move(3'd0, 3'd0, 8'hFF, b, 1'b1, 0, lat);
        total++;
        if (lat < 1 || bus.illegal !== 1'b0 || bus.flip_count !== 6'd4) begin
            bad++;
            $display("FAIL multi_result: lat=%0d illegal=%b flip=%0d want done 0 4",
                     lat, bus.illegal, bus.flip_count);
        end
        total++;
        if (bus.board_out !== exp) begin
            bad++;
            $display("FAIL multi_board: got %h want %h", bus.board_out, exp);
        end
    endtask

    task automatic test_occupied();
        int lat;
        run_move(3'd3, 3'd3, 8'hFF, opening_board(), 1'b1, 0, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL occupied_latency: got %0d want 2", lat);
        end
        total++;
        if (bus.illegal !== 1'b1 || bus.flip_count !== 6'd0 || bus.board_out !== opening_board()) begin
            bad++;
            $display("FAIL occupied_result: illegal=%b flip=%0d board=%h want 1 0 %h",
                     bus.illegal, bus.flip_count, bus.board_out, opening_board());
        end
    endtask

    task automatic test_edge_run();
        int lat;
        logic [127:0] b;
        b = 128'd0;
        for (int i = 1; i < 8; i++) b = set_cell(b, i, 0, 2'b10);
        run_move(3'd0, 3'd0, 8'h08, b, 1'b1, 0, lat);
        total++;
        if (lat < 1 || bus.illegal !== 1'b1 || bus.flip_count !== 6'd0 || bus.board_out !== b) begin
            bad++;
            $display("FAIL edge_run: lat=%0d illegal=%b flip=%0d board=%h want done 1 0 %h",
                     lat, bus.illegal, bus.flip_count, bus.board_out, b);
        end
    endtask

    task automatic test_empty_mask();
        int lat;
        run_move(3'd3, 3'd2, 8'h00, opening_board(), 1'b1, 0, lat);
        total++;
        if (lat !== 3 || bus.illegal !== 1'b1 || bus.board_out !== opening_board()) begin
            bad++;
            $display("FAIL empty_mask: lat=%0d illegal=%b board=%h want 3 1 %h",
                     lat, bus.illegal, bus.board_out, opening_board());
        end
    endtask

    task automatic test_reset_mid_flip();
        int lat;
        logic [127:0] exp;
        @(posedge clk);
        #1;
        bus.x            = 3'd3;
        bus.y            = 3'd2;
        bus.dir_mask     = 8'h02;
        bus.board_in     = opening_board();
        bus.player_black = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Engine is in FLIP after the fourth edge past the accepting one.
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.board_out !== 128'd0) begin
            bad++;
            $display("FAIL reset_mid_flip: busy=%b done=%b board=%h want 0 0 0",
                     bus.busy, bus.done, bus.board_out);
        end
        resetn = 1'b1;
        exp = set_cell(opening_board(), 3, 2, 2'b11);
        exp = set_cell(exp, 3, 3, 2'b11);
        run_move(3'd3, 3'd2, 8'h02, opening_board(), 1'b1, 2, lat);
        total++;
        if (lat !== 7 || bus.illegal !== 1'b0 || bus.flip_count !== 6'd1) begin
            bad++;
            $display("FAIL start_while_busy: lat=%0d illegal=%b flip=%0d want 7 0 1",
                     lat, bus.illegal, bus.flip_count);
        end
        total++;
        if (bus.board_out !== exp) begin
            bad++;
            $display("FAIL start_while_busy_board: got %h want %h", bus.board_out, exp);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        resetn           = 1'b0;
        bus.start        = 1'b0;
        bus.x            = 3'd0;
        bus.y            = 3'd0;
        bus.dir_mask     = 8'd0;
        bus.board_in     = 128'd0;
        bus.player_black = 1'b0;
        test_reset();
        test_opening();
        test_all_dirs();
        test_multi_dir();
        test_occupied();
        test_edge_run();
        test_empty_mask();
        test_reset_mid_flip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
